alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Operand-issue stage directly upstream of the execute ALU.
- Accepts a 32-bit MIPS-style instruction word with a valid/ready handshake, decodes R-type and the ALU I-types, reads a 32x32 register file, and resolves hazards with a busy-bit scoreboard.
- Presents rs/rt operands, funct, shamt and destination to the ALU through a one-entry output register.
- Writeback returns results into the register file and clears scoreboard bits.

Parameters:
- NREG, 32, number of architectural registers; r0 is hardwired to zero.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  instruction available
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- wb_en  in  1  writeback strobe
- wb_addr  in  5  writeback register index
- wb_data  in  XLEN  writeback value
- out_valid  out  1  issued operation held for the ALU
- out_ready  in  1  ALU/execute consumes the held operation
- out_rs  out  XLEN  first ALU operand
- out_rt  out  XLEN  second ALU operand (register value or extended immediate)
- out_funct  out  6  ALU function code
- out_shamt  out  5  shift amount
- out_rd_addr  out  5  destination register
- out_we  out  1  destination is written (0 when dest is r0)
- illegal  out  1  one-cycle pulse: unsupported opcode dropped

Behaviour:
- Decode, R-type (opcode 000000):
  - src1 = [25:21], src2 = [20:16], dest = [15:11]
  - shamt = [10:6], funct = [5:0]
- Decode, I-type (dest = [20:16], src1 = [25:21], no src2, shamt = 0):
  - addi 001000 -> funct 100000, imm sign-extended
  - andi 001100 -> funct 100100, imm zero-extended
  - ori 001101 -> funct 100101, imm zero-extended
  - xori 001110 -> funct 100110, imm zero-extended
- Any other opcode:
  - Accepted (consumed) when in_ready=1.
  - Nothing issued, scoreboard unchanged, illegal=1 for the following cycle.
- Hazard:
  - stall = in_valid and (busy[src1] or busy[src2 if used] or busy[dest]).
  - busy[0] is always 0.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !stall.
  - Transfer when in_valid & in_ready.
  - in_ready must not depend combinationally on anything but out_valid, out_ready, in_instr, in_valid, busy and wb inputs.
- Latency: one cycle. An instruction transferred at edge N appears with out_valid=1 after edge N and holds stable until out_ready=1.
- Throughput: one per cycle when out_ready stays high and there are no hazards.
- Output register:
  - On transfer of a legal instruction: load operands/fields, out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
- Register read and bypass:
  - Reads of r0 return 0.
  - If wb_en and wb_addr == source index (nonzero) in the same cycle, the source reads wb_data and busy for that index counts as clear this cycle.
- Register write: on wb_en with wb_addr != 0, regfile[wb_addr] <= wb_data. Writes to r0 are ignored.
- Scoreboard:
  - On issue with dest != 0, busy[dest] <= 1.
  - wb_en clears busy[wb_addr].
  - If set and clear target the same index in the same cycle, set wins.
- Reset:
  - out_valid=0, illegal=0.
  - out_rs/out_rt/out_funct/out_shamt/out_rd_addr/out_we = 0.
  - All busy bits 0, all registers 0.
  - Reset mid-operation discards the held operation; in-flight writebacks arriving after reset still write the register file.
- Width: immediate extension to XLEN; no arithmetic performed in this block.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI
  - ALU funct constants: FUNCT_ADD/SUB/AND/OR/XOR/NOR/SLL/SRL/SRA
  - field bit positions
- Sub-module regfile_2r1w: 2 async read ports, 1 sync write port, r0 = 0, write-through bypass, synchronous clear on rst.
- Decode, scoreboard and output register stay in alu_issue.

Test Plan:
- Reset, then idle -> out_valid=0, in_ready=1, all outputs 0; read r5 via R-type issue -> out_rs=0.
- wb r3=0x0000000A and r4=0x00000005 are written and retired, then add r5,r3,r4 (0x00642820) -> next cycle out_rs=0xA, out_rt=0x5, out_funct=100000, out_rd_addr=5, out_we=1; busy[5]=1.
- addi r6,r0,-1 (0x2006FFFF) -> out_rt=0xFFFFFFFF, funct 100000. ori r6,r0,0xFFFF -> out_rt=0x0000FFFF.
- RAW: issue add r5,…, then sub r7,r5,r4 -> in_ready=0 until wb r5; in the wb cycle with wb_data=0x1234, transfer occurs and out_rs=0x1234.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> next instruction issues on the following edge.
- Opcode 100011 -> nothing issued, illegal pulses exactly 1 cycle, busy unchanged. Dest r0 instruction -> out_we=0, busy unchanged.

Source files
------------

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_pkg
//  Description : Shared opcode/funct constants, instruction field positions
//                and the decode helper for the ALU operand-issue stage.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_issue_pkg;

    // Major opcodes handled by the issue stage
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    // ALU function codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_SRA = 6'b000011;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SH_MSB  = 10;
    localparam int SH_LSB  = 6;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Decoded view of one instruction word
    typedef struct packed {
        logic        legal;     // opcode is supported
        logic        use_src2;  // R-type: second operand comes from rt
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dest;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic        imm_sext;  // sign-extend the immediate (addi only)
        logic [15:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d          = '0;
        d.src1     = instr[RS_MSB:RS_LSB];
        d.src2     = instr[RT_MSB:RT_LSB];
        d.dest     = instr[RT_MSB:RT_LSB];
        d.imm      = instr[IMM_MSB:IMM_LSB];
        case (instr[OP_MSB:OP_LSB])
            OP_RTYPE: begin
                d.legal    = 1'b1;
                d.use_src2 = 1'b1;
                d.dest     = instr[RD_MSB:RD_LSB];
                d.shamt    = instr[SH_MSB:SH_LSB];
                d.funct    = instr[FN_MSB:FN_LSB];
            end
            OP_ADDI: begin
                d.legal    = 1'b1;
                d.funct    = FUNCT_ADD;
                d.imm_sext = 1'b1;
            end
            OP_ANDI: begin
                d.legal    = 1'b1;
                d.funct    = FUNCT_AND;
            end
            OP_ORI: begin
                d.legal    = 1'b1;
                d.funct    = FUNCT_OR;
            end
            OP_XORI: begin
                d.legal    = 1'b1;
                d.funct    = FUNCT_XOR;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : Register file, two asynchronous read ports, one synchronous
//                write port, r0 hardwired to zero, write-through bypass and
//                synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_2r1w #(
    parameter  int NREG = 32,
    parameter  int XLEN = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] r_mem [NREG];

    // Storage: clear on reset, otherwise write any register except r0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            r_mem[wa] <= wd;
        end
    end

    // Reads: r0 is zero; a same-cycle write to the read index is forwarded
    assign rd1 = (ra1 == '0)             ? '0 :
                 (we && (wa == ra1))     ? wd : r_mem[ra1];
    assign rd2 = (ra2 == '0)             ? '0 :
                 (we && (wa == ra2))     ? wd : r_mem[ra2];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Operand-issue stage in front of the execute ALU. Decodes
//                R-type and ALU I-type instructions, reads operands, tracks
//                pending destinations in a busy-bit scoreboard and holds the
//                issued operation in a one-entry output register.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs,
    output logic [XLEN-1:0] out_rt,
    output logic [5:0]      out_funct,
    output logic [4:0]      out_shamt,
    output logic [4:0]      out_rd_addr,
    output logic            out_we,
    output logic            illegal
);

    dec_t            w_dec;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_imm_ext;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_eff;
    logic [NREG-1:0] w_busy_next;
    logic            w_stall;
    logic            w_xfer;
    logic            w_issue;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_rs;
    logic [XLEN-1:0] r_out_rt;
    logic [5:0]      r_out_funct;
    logic [4:0]      r_out_shamt;
    logic [4:0]      r_out_rd_addr;
    logic            r_out_we;
    logic            r_illegal;

    assign w_dec = decode(in_instr);

    regfile_2r1w #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (w_dec.src1),
        .ra2 (w_dec.src2),
        .rd1 (w_rd1),
        .rd2 (w_rd2),
        .we  (wb_en),
        .wa  (wb_addr),
        .wd  (wb_data)
    );

    // Busy view for this cycle: a writeback landing now already clears its bit
    always_comb begin
        w_busy_eff = r_busy;
        if (wb_en) begin
            w_busy_eff[wb_addr] = 1'b0;
        end
        w_busy_eff[0] = 1'b0;
    end

    assign w_stall  = in_valid & (w_busy_eff[w_dec.src1]
                    | (w_dec.use_src2 & w_busy_eff[w_dec.src2])
                    | w_busy_eff[w_dec.dest]);
    assign in_ready = (!r_out_valid | out_ready) & !w_stall;
    assign w_xfer   = in_valid & in_ready;
    assign w_issue  = w_xfer & w_dec.legal;

    assign w_imm_ext = w_dec.imm_sext ? {{(XLEN-16){w_dec.imm[15]}}, w_dec.imm}
                                      : {{(XLEN-16){1'b0}}, w_dec.imm};

    // Scoreboard next state: clear on writeback, then set on issue (set wins)
    always_comb begin
        w_busy_next = w_busy_eff;
        if (w_issue && (w_dec.dest != 5'd0)) begin
            w_busy_next[w_dec.dest] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // One-entry output register plus the illegal-opcode pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_rs      <= '0;
            r_out_rt      <= '0;
            r_out_funct   <= '0;
            r_out_shamt   <= '0;
            r_out_rd_addr <= '0;
            r_out_we      <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_illegal <= w_xfer & !w_dec.legal;
            if (w_issue) begin
                r_out_valid   <= 1'b1;
                r_out_rs      <= w_rd1;
                r_out_rt      <= w_dec.use_src2 ? w_rd2 : w_imm_ext;
                r_out_funct   <= w_dec.funct;
                r_out_shamt   <= w_dec.shamt;
                r_out_rd_addr <= w_dec.dest;
                r_out_we      <= (w_dec.dest != 5'd0);
            end else if (out_ready) begin
                r_out_valid   <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_rs      = r_out_rs;
    assign out_rt      = r_out_rt;
    assign out_funct   = r_out_funct;
    assign out_shamt   = r_out_shamt;
    assign out_rd_addr = r_out_rd_addr;
    assign out_we      = r_out_we;
    assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Self-checking bench for alu_issue: table of directed
//                instructions with hand-computed results, plus sequences for
//                RAW stall, backpressure, illegal opcode and mid-run reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs;
    logic [31:0] out_rt;
    logic [5:0]  out_funct;
    logic [4:0]  out_shamt;
    logic [4:0]  out_rd_addr;
    logic        out_we;
    logic        illegal;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue #(.NREG(32), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_funct   (out_funct),
        .out_shamt   (out_shamt),
        .out_rd_addr (out_rd_addr),
        .out_we      (out_we),
        .illegal     (illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] retire;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        @(negedge clk);
        wb_en   = 1'b0;
    endtask

    initial begin
        // {instr, rs, rt, funct, shamt, rd, we, retire value}
        vecs[0] = '{32'h00A00825, 32'h0,        32'h0,        6'h25, 5'd0, 5'd1,  1'b1, 32'h11111111}; // or r1,r5,r0
        vecs[1] = '{32'h00642820, 32'hA,        32'h5,        6'h20, 5'd0, 5'd5,  1'b1, 32'h55};       // add r5,r3,r4
        vecs[2] = '{32'h2006FFFF, 32'h0,        32'hFFFFFFFF, 6'h20, 5'd0, 5'd6,  1'b1, 32'h66};       // addi r6,r0,-1
        vecs[3] = '{32'h3406FFFF, 32'h0,        32'h0000FFFF, 6'h25, 5'd0, 5'd6,  1'b1, 32'h66};       // ori r6,r0,0xFFFF
        vecs[4] = '{32'h30678001, 32'hA,        32'h00008001, 6'h24, 5'd0, 5'd7,  1'b1, 32'h77};       // andi r7,r3,0x8001
        vecs[5] = '{32'h388800F0, 32'h5,        32'h000000F0, 6'h26, 5'd0, 5'd8,  1'b1, 32'h88};       // xori r8,r4,0xF0
        vecs[6] = '{32'h00054900, 32'h0,        32'h55,       6'h00, 5'd4, 5'd9,  1'b1, 32'h99};       // sll r9,r5,4
        vecs[7] = '{32'h20C08000, 32'h66,       32'hFFFF8000, 6'h20, 5'd0, 5'd0,  1'b0, 32'h0};        // addi r0,r6,-0x8000
        vecs[8] = '{32'h00255022, 32'h11111111, 32'h55,       6'h22, 5'd0, 5'd10, 1'b1, 32'hAA};       // sub r10,r1,r5
        vecs[9] = '{32'h00E85827, 32'h77,       32'h88,       6'h27, 5'd0, 5'd11, 1'b1, 32'hBB};       // nor r11,r7,r8

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
        chk("rst_out_rs",    out_rs,             32'h0);
        chk("rst_out_rt",    out_rt,             32'h0);
        chk("rst_out_funct", {26'b0, out_funct}, 32'h0);
        chk("rst_out_shamt", {27'b0, out_shamt}, 32'h0);
        chk("rst_out_rd",    {27'b0, out_rd_addr}, 32'h0);
        chk("rst_out_we",    {31'b0, out_we},    32'h0);
        chk("rst_illegal",   {31'b0, illegal},   32'h0);

        wb(5'd3, 32'h0000000A);
        wb(5'd4, 32'h00000005);

        // Table-driven single issues, each retired before the next
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
            chk($sformatf("v%0d_rs", i),    out_rs, vecs[i].rs);
            chk($sformatf("v%0d_rt", i),    out_rt, vecs[i].rt);
            chk($sformatf("v%0d_funct", i), {26'b0, out_funct}, {26'b0, vecs[i].funct});
            chk($sformatf("v%0d_shamt", i), {27'b0, out_shamt}, {27'b0, vecs[i].shamt});
            chk($sformatf("v%0d_rd", i),    {27'b0, out_rd_addr}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_we", i),    {31'b0, out_we}, {31'b0, vecs[i].we});
            @(negedge clk);
            in_valid = 1'b0;
            if (vecs[i].we) wb(vecs[i].rd, vecs[i].retire);
        end

        // RAW: add r5,r3,r4 then sub r7,r5,r4 stalls until r5 writes back
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h00642820;
        @(posedge clk);
        #1;
        chk("raw_add_valid", {31'b0, out_valid}, 32'h1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_instr = 32'h00A43822;
            #1;
            chk($sformatf("raw_stall%0d", c), {31'b0, in_ready}, 32'h0);
            @(posedge clk);
        end
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        #1;
        chk("raw_wb_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("raw_valid", {31'b0, out_valid}, 32'h1);
        chk("raw_rs",    out_rs, 32'h1234);
        chk("raw_rt",    out_rt, 32'h5);
        chk("raw_funct", {26'b0, out_funct}, 32'h22);
        chk("raw_rd",    {27'b0, out_rd_addr}, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        wb_en    = 1'b0;
        wb(5'd7, 32'h777);

        // Backpressure: xori r8,r4,0xF0 held while ori r12 waits
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h388800F0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_instr = 32'h340C1234;
            #1;
            chk($sformatf("bp%0d_in_ready", c), {31'b0, in_ready}, 32'h0);
            chk($sformatf("bp%0d_valid", c),    {31'b0, out_valid}, 32'h1);
            chk($sformatf("bp%0d_rs", c),       out_rs, 32'h5);
            chk($sformatf("bp%0d_rt", c),       out_rt, 32'hF0);
            chk($sformatf("bp%0d_rd", c),       {27'b0, out_rd_addr}, 32'd8);
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("bp_next_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_next_rt",    out_rt, 32'h1234);
        chk("bp_next_rd",    {27'b0, out_rd_addr}, 32'd12);
        chk("bp_next_funct", {26'b0, out_funct}, 32'h25);
        @(negedge clk);
        in_valid = 1'b0;
        wb(5'd8, 32'h88);
        wb(5'd12, 32'h1234);

        // Illegal opcode 100011: dropped, one-cycle pulse, r13 not marked busy
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h8C0D0000;
        #1;
        chk("ill_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("ill_pulse",     {31'b0, illegal},   32'h1);
        chk("ill_no_issue",  {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        in_instr = 32'h01A07025;                     // or r14,r13,r0
        #1;
        chk("ill_busy_clean", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("ill_pulse_end", {31'b0, illegal},   32'h0);
        chk("ill_next_valid", {31'b0, out_valid}, 32'h1);
        chk("ill_next_rs",   out_rs, 32'h0);
        chk("ill_next_rd",   {27'b0, out_rd_addr}, 32'd14);
        @(negedge clk);
        in_valid = 1'b0;
        wb(5'd14, 32'hEE);

        // Reset while an operation is held
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00A07825;                    // or r15,r5,r0
        @(posedge clk);
        #1;
        chk("mr_held_valid", {31'b0, out_valid}, 32'h1);
        chk("mr_held_rs",    out_rs, 32'h1234);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_valid", {31'b0, out_valid}, 32'h0);
        chk("mr_rs",    out_rs, 32'h0);
        chk("mr_we",    {31'b0, out_we}, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h01E58025;                    // or r16,r15,r5
        #1;
        chk("mr_busy_cleared", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("mr_post_valid", {31'b0, out_valid}, 32'h1);
        chk("mr_post_rs",    out_rs, 32'h0);
        chk("mr_post_rt",    out_rt, 32'h0);
        chk("mr_post_rd",    {27'b0, out_rd_addr}, 32'd16);
        @(negedge clk);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
